// File: rtl/general_defines.sv
// Shared widths and types for the branch-target path: PC width, BTB update
// queue sizing, and the queued update record.
package general_defines;

  localparam int INSTR_MEM_IDX_W = 16;
  localparam int BTB_UPDQ_DEPTH  = 4;
  localparam int BTB_UPDQ_PTR_W  = $clog2(BTB_UPDQ_DEPTH);

  typedef struct packed {
    logic [INSTR_MEM_IDX_W-1:0] pc;
    logic [INSTR_MEM_IDX_W-1:0] target;
  } btb_upd_t;

endpackage

// File: rtl/btb_update_queue.sv
// Collects mispredicted-taken branch resolutions from two ports, merges repeats
// to the same PC, and drains one update per cycle into the BTB write port.
module btb_update_queue
  import general_defines::*;
(
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  logic [1:0]                        res_valid,
  input  logic [1:0]                        res_taken,
  input  logic [1:0]                        res_pred_ok,
  input  logic [1:0][INSTR_MEM_IDX_W-1:0]   res_pc,
  input  logic [1:0][INSTR_MEM_IDX_W-1:0]   res_target,
  output logic                              res_ready,
  output logic                              update_valid,
  output logic [INSTR_MEM_IDX_W-1:0]        update_pc,
  output logic [INSTR_MEM_IDX_W-1:0]        update_target
);

  localparam int PTR_W = BTB_UPDQ_PTR_W;
  localparam int CNT_W = BTB_UPDQ_PTR_W + 1;
  localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(BTB_UPDQ_DEPTH - 2);

  btb_upd_t               r_mem [BTB_UPDQ_DEPTH];
  logic [PTR_W-1:0]       r_head;
  logic [PTR_W-1:0]       r_tail;
  logic [CNT_W-1:0]       r_count;

  logic                         w_deq;
  logic [1:0]                   w_q;
  logic [PTR_W-1:0]             w_off  [BTB_UPDQ_DEPTH];
  logic [BTB_UPDQ_DEPTH-1:0]    w_live;
  logic [1:0]                   w_hit;
  logic [1:0][PTR_W-1:0]        w_hit_idx;
  logic                         w_same;
  logic                         w_alloc0;
  logic                         w_alloc1;
  logic [PTR_W-1:0]             w_idx0;
  logic [PTR_W-1:0]             w_idx1;

  assign w_deq     = (r_count != '0);
  assign res_ready = (r_count <= READY_MAX);

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_q[p] = res_valid[p] & res_ready & res_taken[p] & ~res_pred_ok[p] & ~flush;
    end
  end

  // An entry can absorb a merge only if it is occupied and is not the head,
  // because the head leaves the queue at this edge.
  always_comb begin
    for (int i = 0; i < BTB_UPDQ_DEPTH; i++) begin
      w_off[i]  = PTR_W'(i) - r_head;
      w_live[i] = (w_off[i] != '0) && (CNT_W'(w_off[i]) < r_count);
    end
  end

  // NOTE: every combinational output gets a default before the loop so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_hit     = '0;
    w_hit_idx = '0;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < BTB_UPDQ_DEPTH; i++) begin
        if (w_live[i] && (r_mem[i].pc == res_pc[p])) begin
          w_hit[p]     = 1'b1;
          w_hit_idx[p] = PTR_W'(i);
        end
      end
    end
  end

  // Port 0 is placed first; a same-PC port 1 lands on port 0's slot so its
  // target is the one that survives.
  assign w_same   = w_q[0] & w_q[1] & (res_pc[0] == res_pc[1]);
  assign w_alloc0 = w_q[0] & ~w_hit[0];
  assign w_alloc1 = w_q[1] & ~w_same & ~w_hit[1];
  assign w_idx0   = w_hit[0] ? w_hit_idx[0] : r_tail;
  assign w_idx1   = w_same   ? w_idx0 :
                    w_hit[1] ? w_hit_idx[1] : r_tail + PTR_W'(w_alloc0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PTR_W'(w_deq);
      r_tail  <= r_tail + PTR_W'(w_alloc0) + PTR_W'(w_alloc1);
      r_count <= r_count + CNT_W'(w_alloc0) + CNT_W'(w_alloc1) - CNT_W'(w_deq);
    end
  end

  // NOTE: the storage array has no reset; occupancy is tracked by r_count,
  // so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (w_q[0]) r_mem[w_idx0] <= '{pc: res_pc[0], target: res_target[0]};
    if (w_q[1]) r_mem[w_idx1] <= '{pc: res_pc[1], target: res_target[1]};
  end

  assign update_valid  = w_deq;
  assign update_pc     = w_deq ? r_mem[r_head].pc     : '0;
  assign update_target = w_deq ? r_mem[r_head].target : '0;

endmodule
